// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard and stall controller for a three-stage in-order RISC-V pipeline
// (fetch/decode, execute, memory/writeback). It detects load-use hazards
// between stages 1 and 2. It flushes the front end after a stage-3 PC
// redirect. It freezes the whole pipe while the memory/IO side requests a
// wait. Two optional performance counters are also provided.
//
// Optional feature macro: PIPE_PERF_CNT_EN
//   defined   -> cycle_cnt / inst_cnt are live 32-bit wrapping counters
//   undefined -> both counters read 0 and no counter flops are built
//
// Parameters
//   FLUSH_CYCLES  extra stage-1 flush cycles after a redirect (1..3)
//
// Ports
//   clk            sole clock, rising edge
//   rst            synchronous, active-high reset
//   inst_s1        instruction in fetch/decode
//   inst_s2        instruction in execute
//   redirect       stage-3 PC redirect (taken branch, JAL, JALR)
//   mem_stall_req  multi-cycle memory/IO wait request
//   retire_valid   stage 3 holds a real instruction
//   cnt_clr        counter clear strobe (MMIO)
//   stall_s1..s3   hold the corresponding pipeline register
//   flush_s1/s2    replace the stage's instruction with NOP
//   bubble_s2      insert a NOP into stage 2 while stage 1 holds
//   cycle_cnt      cycles since reset / last clear
//   inst_cnt       retired instructions since reset / last clear
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_s1,
    input  logic [31:0] inst_s2,
    input  logic        redirect,
    input  logic        mem_stall_req,
    input  logic        retire_valid,
    input  logic        cnt_clr,
    output logic        stall_s1,
    output logic        stall_s2,
    output logic        stall_s3,
    output logic        flush_s1,
    output logic        flush_s2,
    output logic        bubble_s2,
    output logic [31:0] cycle_cnt,
    output logic [31:0] inst_cnt
);

    // RV32I major opcodes that matter for register-use decoding
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        FLUSH  = 2'd2,
        MWAIT  = 2'd3
    } state_t;

    state_t     state, state_nxt;
    state_t     saved, saved_nxt;   // state interrupted by a memory wait
    state_t     eff_state;          // state whose rules apply this cycle
    logic [1:0] flush_cnt, flush_cnt_nxt;

    // -----------------------------------------------------------------------
    // Load-use detection
    // -----------------------------------------------------------------------
    logic [6:0] opc_s1;
    logic [4:0] rs1_s1, rs2_s1, rd_s2;
    logic       s2_is_load, s1_reads_rs1, s1_reads_rs2, load_use;

    assign opc_s1 = inst_s1[6:0];
    assign rs1_s1 = inst_s1[19:15];
    assign rs2_s1 = inst_s1[24:20];
    assign rd_s2  = inst_s2[11:7];

    // LOAD is the only major opcode with bits [6:2] all zero.
    assign s2_is_load   = (inst_s2[6:2] == 5'b00000);
    // U-type and JAL carry immediate bits in the rs1 field.
    assign s1_reads_rs1 = !((opc_s1 == OPC_LUI) || (opc_s1 == OPC_AUIPC) ||
                            (opc_s1 == OPC_JAL));
    assign s1_reads_rs2 = (opc_s1 == OPC_OP) || (opc_s1 == OPC_STORE) ||
                          (opc_s1 == OPC_BRANCH);

    assign load_use = s2_is_load && (rd_s2 != 5'd0) &&
                      ((s1_reads_rs1 && (rs1_s1 == rd_s2)) ||
                       (s1_reads_rs2 && (rs2_s1 == rd_s2)));

    // -----------------------------------------------------------------------
    // Next-state and output decode
    // -----------------------------------------------------------------------
    // While waiting on memory the saved state is the one that resumes, so
    // the cycle mem_stall_req drops already behaves as the interrupted state.
    assign eff_state = (state == MWAIT) ? saved : state;

    always_comb begin
        // NOTE: every output of this block is given a default first; a path
        // that skips an assignment would otherwise infer a latch.
        stall_s1      = 1'b0;
        stall_s2      = 1'b0;
        stall_s3      = 1'b0;
        flush_s1      = 1'b0;
        flush_s2      = 1'b0;
        bubble_s2     = 1'b0;
        state_nxt     = state;
        saved_nxt     = saved;
        flush_cnt_nxt = flush_cnt;

        if (rst) begin
            // Outputs stay low; the register block forces the reset state.
        end else if (mem_stall_req) begin
            // Highest priority: freeze everything, remember what we were doing.
            stall_s1  = 1'b1;
            stall_s2  = 1'b1;
            stall_s3  = 1'b1;
            state_nxt = MWAIT;
            if (state != MWAIT) begin
                saved_nxt = state;
            end
        end else begin
            state_nxt = RUN;
            saved_nxt = RUN;
            unique case (eff_state)
                RUN: begin
                    if (redirect) begin
                        flush_s1      = 1'b1;
                        flush_s2      = 1'b1;
                        state_nxt     = FLUSH;
                        flush_cnt_nxt = FLUSH_LOAD;
                    end else if (load_use) begin
                        stall_s1  = 1'b1;
                        bubble_s2 = 1'b1;
                        state_nxt = LSTALL;
                    end
                end
                LSTALL: begin
                    // The load has moved on; the held consumer is now safe.
                    if (redirect) begin
                        flush_s1      = 1'b1;
                        flush_s2      = 1'b1;
                        state_nxt     = FLUSH;
                        flush_cnt_nxt = FLUSH_LOAD;
                    end
                end
                FLUSH: begin
                    flush_s1 = 1'b1;
                    if (redirect) begin
                        // A fresh redirect also kills stage 2 and restarts
                        // the count.
                        flush_s2      = 1'b1;
                        state_nxt     = FLUSH;
                        flush_cnt_nxt = FLUSH_LOAD;
                    end else if (flush_cnt > 2'd1) begin
                        state_nxt     = FLUSH;
                        flush_cnt_nxt = flush_cnt - 2'd1;
                    end else begin
                        flush_cnt_nxt = 2'd0;
                    end
                end
                default: begin
                    // MWAIT is never saved; fall back to RUN.
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the values from before this edge.
        if (rst) begin
            state     <= RUN;
            saved     <= RUN;
            flush_cnt <= 2'd0;
        end else begin
            state     <= state_nxt;
            saved     <= saved_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Performance counters
    // -----------------------------------------------------------------------
`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cycle_cnt <= 32'd0;
            inst_cnt  <= 32'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            // A stalled stage 3 retires its instruction later, not now.
            if (retire_valid && !stall_s3) begin
                inst_cnt <= inst_cnt + 32'd1;
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{inst_s1[31:25], inst_s1[14:7],
                           inst_s2[31:12], inst_s2[1:0]};
`else
    assign cycle_cnt = 32'd0;
    assign inst_cnt  = 32'd0;

    logic unused_bits;
    assign unused_bits = ^{inst_s1[31:25], inst_s1[14:7],
                           inst_s2[31:12], inst_s2[1:0],
                           retire_valid, cnt_clr};
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 1, extra fetch-flush cycles after a redirect; legal range 1..3.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port inst_s1  input  32  instruction in fetch/decode stage.
REQ-005 SHALL have port inst_s2  input  32  instruction in execute stage.
REQ-006 SHALL have port redirect  input  1  stage-3 PC redirect (taken branch, JAL, JALR).
REQ-007 SHALL have port mem_stall_req  input  1  multi-cycle memory/IO wait request.
REQ-008 SHALL have port retire_valid  input  1  stage-3 holds a real (non-bubble) instruction.
REQ-009 SHALL have port cnt_clr  input  1  MMIO counter-reset strobe.
REQ-010 SHALL have ports stall_s1, stall_s2, stall_s3  output  1 each  hold the stage's pipeline register.
REQ-011 SHALL have ports flush_s1, flush_s2  output  1 each  replace the stage's instruction with NOP (0x00000013).
REQ-012 SHALL have port bubble_s2  output  1  insert NOP into stage 2 while stage 1 holds.
REQ-013 SHALL have ports cycle_cnt, inst_cnt  output  32 each  performance counters.

Function
REQ-014 SHALL implement a registered FSM with states RUN, LSTALL, FLUSH, MWAIT.
REQ-015 SHALL detect load-use: inst_s2[6:2]=00000, rd=inst_s2[11:7]≠0, and rd equals inst_s1 rs1 (all opcodes except LUI, AUIPC, JAL) or rs2 (R-type, STORE, BRANCH).
REQ-016 SHALL, on load-use in RUN, assert stall_s1 and bubble_s2 combinationally that cycle, then enter LSTALL for exactly one cycle and return to RUN with no outputs asserted.
REQ-017 SHALL, on redirect in RUN or LSTALL, assert flush_s1 and flush_s2 combinationally that cycle, then enter FLUSH for FLUSH_CYCLES cycles asserting only flush_s1, then return to RUN.
REQ-018 SHALL, while mem_stall_req=1 in any state, assert stall_s1, stall_s2, stall_s3 and enter/remain in MWAIT; flush and bubble outputs forced 0.
REQ-019 SHALL save the interrupted state (LSTALL or FLUSH with remaining count) on entering MWAIT and resume it the cycle after mem_stall_req falls.
REQ-020 SHALL resolve simultaneous events with priority mem_stall_req > redirect > load-use; a redirect coinciding with load-use suppresses stall_s1/bubble_s2.
REQ-021 SHALL treat a redirect arriving in FLUSH as restarting the flush count.
REQ-022 SHALL increment cycle_cnt by 1 every non-reset cycle, wrapping 0xFFFFFFFF→0.
REQ-023 SHALL increment inst_cnt when retire_valid=1 and stall_s3=0, wrapping at 2^32.
REQ-024 SHALL, when cnt_clr=1, load both counters with 0 next cycle; clear wins over increment.

Reset
REQ-025 SHALL, when rst=1 at a rising edge, set state RUN, flush count 0, saved state RUN, cycle_cnt 0, inst_cnt 0.
REQ-026 SHALL hold all stall, flush, bubble outputs at 0 while rst=1, regardless of other inputs.
REQ-027 SHALL abort any LSTALL, FLUSH or MWAIT in progress when rst asserts mid-operation.

Configuration
REQ-028 SHALL, with macro PIPE_PERF_CNT_EN defined, implement cycle_cnt and inst_cnt per REQ-022..024.
REQ-029 SHALL, without PIPE_PERF_CNT_EN, tie cycle_cnt and inst_cnt to 0, ignore cnt_clr and retire_valid, and instantiate no counter flops.

Verification
REQ-030 SHALL cover: inst_s2=lw x5,0(x1), inst_s1=add x6,x5,x2 -> stall_s1=bubble_s2=1 one cycle, then 0; same with rd=x0 -> no stall.
REQ-031 SHALL cover: redirect pulse 1 cycle, FLUSH_CYCLES=2 -> flush_s1 high 3 cycles, flush_s2 high 1 cycle.
REQ-032 SHALL cover: load-use and redirect same cycle -> flush_s1=flush_s2=1, stall_s1=bubble_s2=0.
REQ-033 SHALL cover: mem_stall_req high 4 cycles during FLUSH (1 remaining) -> all stalls high 4 cycles, flush_s1 high 1 cycle after release.
REQ-034 SHALL cover: cycle_cnt preset near 0xFFFFFFFE, 3 cycles -> 0xFFFFFFFF, 0x0, 0x1; cnt_clr with retire_valid=1 -> inst_cnt=0 next cycle.
REQ-035 SHALL cover: rst asserted during MWAIT -> all outputs 0 that cycle, state RUN after the edge, counters 0.
